// File: rtl/teclado_pin_ctrl.sv
// PIN entry sequencer: filters keypad repeats, buffers four BCD digits, checks
// them against CODE and drives open / fail / lockout indications.
module teclado_pin_ctrl #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int unsigned RELEASE_CYCLES = 1500000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned UNLOCK_CYCLES  = 150000000,
    parameter int unsigned FAIL_CYCLES    = 50000000,
    parameter int unsigned LOCKOUT_CYCLES = 1500000000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_detected,
    input  logic [3:0]  digito,
    output logic [15:0] entry,
    output logic [2:0]  digit_count,
    output logic        key_ack,
    output logic        unlocked,
    output logic        error,
    output logic        locked,
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    localparam int unsigned TMAX_A = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned TMAX_B = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW = $clog2(TMAX + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_FAIL    = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_ARM     = RW'(RELEASE_CYCLES - 1);
    localparam logic [FW-1:0] F_MAX     = FW'(MAX_FAILS);

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [RW-1:0]   rel_q, rel_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [15:0]     entry_q, entry_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic            unlocked_q, error_q, locked_q;

    logic accept, is_digit, is_enter, is_bs, is_clr;

    assign accept   = key_detected && armed_q && (state_q == IDLE || state_q == ENTRY);
    assign is_digit = (digito <= 4'h9);
    assign is_enter = (digito == 4'hA);
    assign is_bs    = (digito == 4'hB);
    assign is_clr   = (digito == 4'hC);

    // Release filter: re-arm only after a full quiet window with no key.
    always_comb begin
        rel_d   = rel_q;
        armed_d = armed_q;
        if (key_detected) begin
            rel_d = '0;
            if (accept) armed_d = 1'b0;
        end else if (rel_q == R_ARM) begin
            armed_d = 1'b1;
        end else begin
            rel_d = rel_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        ack_d   = accept && (digito <= 4'hC);
        case (state_q)
            IDLE: begin
                if (accept && is_digit) begin
                    entry_d = {12'h0, digito};
                    cnt_d   = 3'd1;
                    state_d = ENTRY;
                end else if (accept && is_enter) begin
                    state_d = FAIL;
                end
            end
            ENTRY: begin
                if (accept) begin
                    if (is_digit) begin
                        if (cnt_q < 3'd4) begin
                            entry_d = {entry_q[11:0], digito};
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end else if (is_bs) begin
                        entry_d = entry_q >> 4;
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) state_d = IDLE;
                    end else if (is_clr) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (is_enter) begin
                        state_d = CHECK;
                    end
                end else if (timer_q == T_TIMEOUT) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (cnt_q == 3'd4 && entry_q == CODE) begin
                    fail_d  = '0;
                    state_d = OPEN;
                end else begin
                    state_d = FAIL;
                end
            end
            OPEN: if (timer_q == T_UNLOCK) state_d = IDLE;
            FAIL: if (timer_q == T_FAIL) state_d = (fail_q == F_MAX) ? LOCKOUT : IDLE;
            LOCKOUT: begin
                if (timer_q == T_LOCKOUT) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == FAIL && state_q != FAIL && fail_q != F_MAX)
            fail_d = fail_q + 1'b1;
        // Shared timer; in ENTRY any accepted key counts as activity.
        if (state_d != state_q || state_q == IDLE || (state_q == ENTRY && accept))
            timer_d = '0;
        else
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b1;
            rel_q      <= '0;
            timer_q    <= '0;
            fail_q     <= '0;
            entry_q    <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            rel_q      <= rel_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            unlocked_q <= (state_d == OPEN);
            error_q    <= (state_d == FAIL);
            locked_q   <= (state_d == LOCKOUT);
        end
    end

    assign entry       = entry_q;
    assign digit_count = cnt_q;
    assign key_ack     = ack_q;
    assign unlocked    = unlocked_q;
    assign error       = error_q;
    assign locked      = locked_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_teclado_pin_ctrl.sv
// Scoreboard bench for teclado_pin_ctrl: directed key sequences push expected
// events; a monitor pops one per key_ack pulse or state change.
module tb_teclado_pin_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_ENT = 3'd1, S_CHK = 3'd2,
                           S_OPEN = 3'd3, S_FAIL = 3'd4, S_LOCK = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_detected = 1'b0;
    logic [3:0]  digito = 4'h0;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic        key_ack, unlocked, error, locked;
    logic [2:0]  state_o;

    teclado_pin_ctrl #(
        .CODE(16'h1234), .RELEASE_CYCLES(4), .TIMEOUT_CYCLES(50),
        .UNLOCK_CYCLES(10), .FAIL_CYCLES(5), .LOCKOUT_CYCLES(20), .MAX_FAILS(3)
    ) dut (
        .clk(clk), .rst(rst), .key_detected(key_detected), .digito(digito),
        .entry(entry), .digit_count(digit_count), .key_ack(key_ack),
        .unlocked(unlocked), .error(error), .locked(locked), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [15:0] ent;
        logic [2:0]  cnt;
        logic        ack;
        logic [2:0]  flg;
        int          dwell;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_ev  = 0;

    // dwell < 0 means the length of the previous state is not checked
    function automatic void want(input logic [2:0] st, input logic [15:0] ent,
                                 input logic [2:0] cnt, input logic ack, input int dwell);
        ev_t e;
        e.st = st; e.ent = ent; e.cnt = cnt; e.ack = ack; e.dwell = dwell;
        e.flg = {st == S_OPEN, st == S_FAIL, st == S_LOCK};
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, req);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold = 3, input int gap = 6);
        @(negedge clk);
        key_detected = 1'b1;
        digito       = k;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        key_detected = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Monitor
    logic [2:0] prev_st = 3'd0;
    int         dwell_cnt = 0;
    always @(posedge clk) begin
        ev_t g, e;
        bit  changed, bad;
        #1;
        if (rst) begin
            prev_st   = 3'd0;
            dwell_cnt = 0;
        end else begin
            changed = (state_o != prev_st);
            g.dwell = 0;
            if (changed) begin
                g.dwell   = dwell_cnt;
                dwell_cnt = 1;
            end else begin
                dwell_cnt++;
            end
            if (changed || key_ack) begin
                g.st = state_o; g.ent = entry; g.cnt = digit_count; g.ack = key_ack;
                g.flg = {unlocked, error, locked};
                n_ev++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event%0d: got st=%0d ent=%h cnt=%0d ack=%b flg=%b",
                             n_ev, g.st, g.ent, g.cnt, g.ack, g.flg);
                end else begin
                    e   = exp_q.pop_front();
                    bad = (g.st !== e.st) || (g.ent !== e.ent) || (g.cnt !== e.cnt) ||
                          (g.ack !== e.ack) || (g.flg !== e.flg) ||
                          (e.dwell >= 0 && g.dwell != e.dwell);
                    if (bad) begin
                        n_bad++;
                        $display("FAIL event%0d: got st=%0d ent=%h cnt=%0d ack=%b flg=%b dwell=%0d, want st=%0d ent=%h cnt=%0d ack=%b flg=%b dwell=%0d",
                                 n_ev, g.st, g.ent, g.cnt, g.ack, g.flg, g.dwell,
                                 e.st, e.ent, e.cnt, e.ack, e.flg, e.dwell);
                    end
                end
            end
            prev_st = state_o;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {6'd0, state_o, entry, digit_count, key_ack, unlocked, error, locked}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Correct PIN, with a fifth digit ignored at count 4
        want(S_ENT, 16'h0001, 3'd1, 1'b1, -1); press(4'h1);
        want(S_ENT, 16'h0012, 3'd2, 1'b1, -1); press(4'h2);
        want(S_ENT, 16'h0123, 3'd3, 1'b1, -1); press(4'h3);
        want(S_ENT, 16'h1234, 3'd4, 1'b1, -1); press(4'h4);
        want(S_ENT, 16'h1234, 3'd4, 1'b1, -1); press(4'h5);
        want(S_CHK, 16'h1234, 3'd4, 1'b1, -1);
        want(S_OPEN, 16'h0, 3'd0, 1'b0, 1);
        want(S_IDLE, 16'h0, 3'd0, 1'b0, 10);
        press(4'hA);
        repeat (12) @(negedge clk);

        // Held key gives one ack; a quick re-press is dropped
        want(S_ENT, 16'h0005, 3'd1, 1'b1, -1);
        press(4'h5, 30, 2);
        press(4'h5, 3, 6);
        want(S_IDLE, 16'h0, 3'd0, 1'b1, -1); press(4'hC);

        // Editing, including an ignored 0xD key
        want(S_ENT, 16'h0007, 3'd1, 1'b1, -1); press(4'h7);
        want(S_ENT, 16'h0078, 3'd2, 1'b1, -1); press(4'h8);
        want(S_ENT, 16'h0007, 3'd1, 1'b1, -1); press(4'hB);
        press(4'hD);
        want(S_ENT, 16'h0079, 3'd2, 1'b1, -1); press(4'h9);
        want(S_IDLE, 16'h0, 3'd0, 1'b1, -1); press(4'hC);

        // Two wrong PINs
        for (int r = 0; r < 2; r++) begin
            want(S_ENT, 16'h0009, 3'd1, 1'b1, -1); press(4'h9);
            want(S_ENT, 16'h0099, 3'd2, 1'b1, -1); press(4'h9);
            want(S_ENT, 16'h0999, 3'd3, 1'b1, -1); press(4'h9);
            want(S_ENT, 16'h9999, 3'd4, 1'b1, -1); press(4'h9);
            want(S_CHK, 16'h9999, 3'd4, 1'b1, -1);
            want(S_FAIL, 16'h0, 3'd0, 1'b0, 1);
            want(S_IDLE, 16'h0, 3'd0, 1'b0, 5);
            press(4'hA);
            repeat (2) @(negedge clk);
        end
        // Short entry is the third failure -> lockout
        want(S_ENT, 16'h0001, 3'd1, 1'b1, -1); press(4'h1);
        want(S_CHK, 16'h0001, 3'd1, 1'b1, -1);
        want(S_FAIL, 16'h0, 3'd0, 1'b0, 1);
        want(S_LOCK, 16'h0, 3'd0, 1'b0, 5);
        want(S_IDLE, 16'h0, 3'd0, 1'b0, 20);
        press(4'hA);
        press(4'h1);
        repeat (15) @(negedge clk);
        // Fail count was cleared: a single failure returns to IDLE
        want(S_FAIL, 16'h0, 3'd0, 1'b1, -1);
        want(S_IDLE, 16'h0, 3'd0, 1'b0, 5);
        press(4'hA);
        repeat (2) @(negedge clk);

        // Inactivity timeout
        want(S_ENT, 16'h0003, 3'd1, 1'b1, -1);
        want(S_IDLE, 16'h0, 3'd0, 1'b0, 50);
        press(4'h3);
        repeat (50) @(negedge clk);

        // Reset in the middle of OPEN
        want(S_ENT, 16'h0001, 3'd1, 1'b1, -1); press(4'h1);
        want(S_ENT, 16'h0012, 3'd2, 1'b1, -1); press(4'h2);
        want(S_ENT, 16'h0123, 3'd3, 1'b1, -1); press(4'h3);
        want(S_ENT, 16'h1234, 3'd4, 1'b1, -1); press(4'h4);
        want(S_CHK, 16'h1234, 3'd4, 1'b1, -1);
        want(S_OPEN, 16'h0, 3'd0, 1'b0, 1);
        press(4'hA);
        chk("open_before_rst", {31'd0, unlocked}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", {6'd0, state_o, entry, digit_count, key_ack, unlocked, error, locked}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("events_pending", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
